// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and sizing for the multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned OP_W        = 3;
  localparam int unsigned CNT_W       = 6;
  localparam int unsigned CALC_CYCLES = 32;

  localparam logic [OP_W-1:0] OP_MULT  = 3'd0;
  localparam logic [OP_W-1:0] OP_MULTU = 3'd1;
  localparam logic [OP_W-1:0] OP_DIV   = 3'd2;
  localparam logic [OP_W-1:0] OP_DIVU  = 3'd3;
  localparam logic [OP_W-1:0] OP_MTHI  = 3'd4;
  localparam logic [OP_W-1:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Ops that occupy the iterative datapath.
  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage request/result bundle between the pipeline and the mul/div unit.
interface muldiv_if import muldiv_pkg::*; #(
  parameter int unsigned WIDTH = XLEN
);
  logic             start;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/muldiv_core.sv
// Iterative magnitude datapath: shift-add multiply, restoring divide, sign fix-up.
module muldiv_core import muldiv_pkg::*; #(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi_c,
  output logic [WIDTH-1:0] res_lo_c
);

  localparam int unsigned W2 = 2 * WIDTH;

  // acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q;
  logic             div_q, neg_q, neg_r;

  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum, shifted, trial;
  logic [W2-1:0]    prod_neg;

  // Operand magnitudes and sign flags for the op being accepted.
  always_comb begin
    a_neg  = is_signed & a[WIDTH-1];
    b_neg  = is_signed & b[WIDTH-1];
    a_mag  = a_neg ? WIDTH'(0) - a : a;
    b_mag  = b_neg ? WIDTH'(0) - b : b;
    b_zero = (b == '0);
  end

  // One iteration: add-and-shift-right for mul, trial-subtract-and-shift-left for div.
  always_comb begin
    acc_d   = acc_q;
    sum     = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : (WIDTH+1)'(0));
    shifted = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    trial   = shifted - {1'b0, opnd_q};
    if (div_q) begin
      if (!trial[WIDTH]) begin
        acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_d = {sum, acc_q[WIDTH-1:1]};
    end
  end

  // Datapath registers; a zero divisor suppresses quotient negation so lo reads all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (load) begin
      acc_q  <= {WIDTH'(0), (is_div ? a_mag : b_mag)};
      opnd_q <= is_div ? b_mag : a_mag;
      div_q  <= is_div;
      neg_q  <= (a_neg ^ b_neg) & ~b_zero;
      neg_r  <= a_neg;
    end else if (step) begin
      acc_q  <= acc_d;
    end
  end

  // Signed result fix-up applied to the finished magnitudes.
  always_comb begin
    prod_neg = W2'(0) - acc_q;
    res_hi_c = acc_q[W2-1:WIDTH];
    res_lo_c = acc_q[WIDTH-1:0];
    if (div_q) begin
      res_lo_c = neg_q ? WIDTH'(0) - acc_q[WIDTH-1:0]  : acc_q[WIDTH-1:0];
      res_hi_c = neg_r ? WIDTH'(0) - acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
    end else if (neg_q) begin
      res_hi_c = prod_neg[W2-1:WIDTH];
      res_lo_c = prod_neg[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle mul/div unit with architectural HI/LO; busy stalls the pipeline.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             load_c, step_c;
  logic [WIDTH-1:0] res_hi_c, res_lo_c;

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (load_c),
    .step      (step_c),
    .is_div    (is_div_op(bus.op)),
    .is_signed (is_signed_op(bus.op)),
    .a         (bus.a),
    .b         (bus.b),
    .res_hi_c  (res_hi_c),
    .res_lo_c  (res_lo_c)
  );

  // State, counter and HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next state: accept ops only in IDLE, iterate in CALC, commit in FIX.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    load_c  = 1'b0;
    step_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (is_muldiv(bus.op)) begin
            load_c  = 1'b1;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = ST_CALC;
          end else if (bus.op == OP_MTHI) begin
            hi_d = bus.a;
          end else if (bus.op == OP_MTLO) begin
            lo_d = bus.a;
          end
        end
      end
      ST_CALC: begin
        step_c = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(CALC_CYCLES - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        hi_d    = res_hi_c;
        lo_d    = res_lo_c;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table, random unsigned ops and multi-cycle corner sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic clk;
  logic rst;
  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  res_t        sb[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  vec_t        vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
  endtask

  // Issue a mul/div, optionally poke the unit while busy, then compare against the scoreboard.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input bit intrude);
    int   cyc;
    res_t r;
    drive(op, a, b);
    @(posedge clk); #1;
    bus.start = 1'b0;
    sb.push_back('{hi: eh, lo: el});
    chk("busy_set", 64'(bus.busy), 64'(1));
    cyc = 0;
    while (bus.busy && cyc < 100) begin
      if (cyc == 16) begin
        chk("hold_hi", 64'(bus.hi), 64'(model_hi));
        chk("hold_lo", 64'(bus.lo), 64'(model_lo));
      end
      if (intrude) begin
        case (cyc)
          5: drive(OP_MTHI, 32'h0000AAAA, 32'h0);
          8: drive(OP_MULT, 32'd2, 32'd2);
          6, 9: bus.start = 1'b0;
          default: ;
        endcase
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    chk("latency", 64'(cyc), 64'(33));
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      r = sb.pop_front();
      chk("res_hi", 64'(bus.hi), 64'(r.hi));
      chk("res_lo", 64'(bus.lo), 64'(r.lo));
      model_hi = r.hi;
      model_lo = r.lo;
    end
  endtask

  // MTHI/MTLO while idle: one-edge latency, busy never rises.
  task automatic mt_op(input logic [2:0] op, input logic [31:0] a);
    drive(op, a, 32'h0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (op == OP_MTHI) model_hi = a;
    else model_lo = a;
    chk("mt_busy", 64'(bus.busy), 64'(0));
    chk("mt_hi", 64'(bus.hi), 64'(model_hi));
    chk("mt_lo", 64'(bus.lo), 64'(model_lo));
    @(posedge clk); #1;
    chk("mt_busy_after", 64'(bus.busy), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] p;

    vecs[0] = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{OP_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF};
    vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[6] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[7] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[9] = '{OP_MULT,  32'd12345,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFCFC7};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_hi", 64'(bus.hi), 64'(0));
    chk("rst_lo", 64'(bus.lo), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b0);
    end

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 0) rb = 32'd1;
      if (i % 2 == 0) begin
        p = 64'(ra) * 64'(rb);
        run_op(OP_MULTU, ra, rb, p[63:32], p[31:0], 1'b0);
      end else begin
        run_op(OP_DIVU, ra, rb, ra % rb, ra / rb, 1'b0);
      end
    end

    // MTHI and a second MULT arrive while busy and must both be dropped.
    run_op(OP_MULT, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1);
    mt_op(OP_MTLO, 32'h00000055);
    mt_op(OP_MTHI, 32'hDEADBEEF);

    // Reset in the middle of a divide, then start right after release.
    drive(OP_DIV, 32'd100, 32'd7);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy", 64'(bus.busy), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_hi", 64'(bus.hi), 64'(0));
    chk("abort_lo", 64'(bus.lo), 64'(0));
    sb.delete();
    model_hi = '0;
    model_lo = '0;
    run_op(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'h0000000C, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
